// File: rtl/risc8_pwm_led.sv
// risc8_pwm_led: N-channel PWM driver for the risc8 SoC LED/GPIO pins.
// A prescaler generates PWM ticks; CPU writes land in shadow registers and are
// committed to the active duties only at the period boundary (counter wrap).
// Optional fade mode: define RISC8_PWM_FADE_EN so that at each boundary every
// active duty steps by one toward its shadow value instead of loading it.
`timescale 1ns/1ps
module risc8_pwm_led #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_addr,
  input  logic [WIDTH-1:0]                                   wr_data,
  output logic [CHANNELS-1:0]                                pwm_out,
  output logic                                               period_start
);

  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};
  localparam logic [AW:0] ChanCount = (AW+1)'(CHANNELS);
  localparam logic OffLevel = (ACTIVE_LOW != 0);

  logic                           tick;
  logic                           boundary;
  logic                           wrHit;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;
  logic [CHANNELS-1:0]            on;
  logic [CHANNELS-1:0]            pwmOut_q, pwmOut_d;
  logic                           periodStart_q;

  generate
    if (PRESCALE == 1) begin : g_noPresc
      assign tick = 1'b1;
    end else begin : g_presc
      localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);
      logic [PW-1:0] presc_q, presc_d;

      // Prescale counter runs 0..PRESCALE-1 and wraps on the tick cycle
      always_comb begin
        presc_d = (presc_q == PrescMax) ? '0 : presc_q + PW'(1);
      end

      // Prescale counter register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
      end

      assign tick = (presc_q == PrescMax);
    end
  endgenerate

  // The boundary is the tick on which the PWM counter wraps back to zero
  assign boundary = tick && (cnt_q == CntMax);
  assign wrHit    = wr_en && ({1'b0, wr_addr} < ChanCount);

  // PWM counter advances one step per tick and wraps naturally at 2^WIDTH
  always_comb begin
    cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;
  end

  // Shadow next-state: an in-range write replaces that channel's shadow value
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wrHit && (wr_addr == AW'(i))) shadow_d[i] = wr_data;
    end
  end

  // Active duties change only at the boundary, using the post-write shadow so a
  // write landing on the boundary edge takes effect for the new period
  always_comb begin
    active_d = active_q;
    if (boundary) begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef RISC8_PWM_FADE_EN
        if (active_q[i] < shadow_d[i])      active_d[i] = active_q[i] + WIDTH'(1);
        else if (active_q[i] > shadow_d[i]) active_d[i] = active_q[i] - WIDTH'(1);
`else
        active_d[i] = shadow_d[i];
`endif
      end
    end
  end

  // Per-channel compare; duty 0 never turns on and full scale leaves one tick off
  always_comb begin
    on = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      on[i] = (cnt_q < active_q[i]);
    end
  end

  assign pwmOut_d = on ^ {CHANNELS{OffLevel}};

  // State registers; reset forces all outputs to their off level immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pwmOut_q      <= {CHANNELS{OffLevel}};
      periodStart_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pwmOut_q      <= pwmOut_d;
      periodStart_q <= boundary;
    end
  end

  assign pwm_out      = pwmOut_q;
  assign period_start = periodStart_q;

endmodule

// File: doc/risc8_pwm_led.md
Name: risc8_pwm_led

Overview:
- Parametrised N-channel PWM driver for the risc8 SoC LED and GPIO outputs. It replaces direct on/off port-bit drive of the RGB LED pins with per-channel duty control.
- A built-in prescaler generalises the fixed 3-bit clock divider. CPU-side writes land in shadow registers. These are committed glitch-free at the PWM period boundary.
- Sits between the risc8_soc peripheral bus and the board output pins.

Parameters:
- CHANNELS, 3, number of PWM outputs (1..16).
- WIDTH, 8, duty and counter resolution in bits (2..16); period = 2^WIDTH ticks.
- PRESCALE, 8, clk cycles per PWM tick (1..65536); 1 = tick every clk.
- ACTIVE_LOW, 1, 1 = outputs inverted (on drives 0), for common-anode LEDs.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  duty write strobe, sampled on rising clk
- wr_addr  input  max(1,$clog2(CHANNELS))  channel index for write
- wr_data  input  WIDTH  duty value for write
- pwm_out  output  CHANNELS  registered PWM outputs, polarity per ACTIVE_LOW
- period_start  output  1  one-clk pulse on the cycle the PWM counter wraps to 0

Behaviour:
- Reset (async, active-high) sets the following immediately, independent of clk:
  - prescale counter = 0, PWM counter = 0;
  - all shadow and active duties = 0;
  - period_start = 0;
  - pwm_out = {CHANNELS{ACTIVE_LOW}}, i.e. all off.
- Prescaler:
  - Counts 0..PRESCALE-1 on every clk.
  - tick = (count == PRESCALE-1); the count then returns to 0.
  - With PRESCALE=1, tick is constant 1.
- PWM counter:
  - WIDTH bits; increments by 1 on each tick.
  - Wraps from 2^WIDTH-1 to 0 with no dead cycle.
- Boundary:
  - Defined as the tick on which the PWM counter wraps to 0.
  - On the same clk edge, every active duty loads its shadow.
  - period_start is registered high for exactly that one clk and low on all other clks.
  - The first boundary after reset occurs after 2^WIDTH*PRESCALE clks.
- Writes:
  - wr_en=1 with wr_addr<CHANNELS stores wr_data into shadow[wr_addr] at that edge.
  - wr_addr>=CHANNELS is silently ignored.
  - A write never alters an active duty mid-period.
  - Write coinciding with a boundary edge: the written value bypasses into the active register in that same edge. Last write wins.
- Compare:
  - on[i] = (pwm_cnt < active[i]), unsigned WIDTH-bit compare.
  - duty 0 = never on. duty 2^WIDTH-1 = on for all but one tick per period.
  - No 100% setting exists by design.
- Output:
  - pwm_out[i] = on[i] ^ ACTIVE_LOW, registered.
  - pwm_out lags pwm_cnt by exactly one clk.
  - All channels switch on the same clk edge; no combinational path from the inputs to pwm_out.
- Reset mid-period:
  - Discards any pending shadow values.
  - After release, the counter restarts at 0 with all duties 0.

Optional Feature:
- Macro: RISC8_PWM_FADE_EN.
- Defined (fade mode): at each boundary, each active duty steps by exactly 1 toward its shadow value instead of loading it.
  - Moves up 1 if below, down 1 if above, holds if equal.
  - The write-bypass rule becomes: a write at a boundary sets the shadow, and the step is taken toward the new value.
- Undefined: active duty loads the shadow directly at each boundary, as described in Behaviour.

Test Plan:
- Reset and idle: assert reset mid-run with CHANNELS=3, WIDTH=4, PRESCALE=2, ACTIVE_LOW=1.
  - pwm_out must equal 3'b111 immediately, before any clk edge.
  - period_start must be 0.
  - After release, the first period_start must occur 32 clks later.
- Duty write and commit: write ch0=4, ch1=15, ch2=0 mid-period.
  - Outputs must stay off until the next period_start.
  - Over each following 32-clk period, count low (on) clks: ch0=8, ch1=30, ch2=0.
- Shadow isolation: during period k, write ch0=4, then ch0=12 (both writes mid-period).
  - Period k must still use the old duty.
  - Period k+1 must show 24 on-clks for ch0.
- Boundary collision and bad address:
  - Write ch1=6 on exactly the period_start edge: 12 on-clks in that same period.
  - Write wr_addr=3 with wr_data=9: no channel changes.
- Polarity and prescale: with ACTIVE_LOW=0, PRESCALE=1, WIDTH=2, duty=2.
  - Output must be 1,1,0,0 repeating.
  - period_start must pulse every 4 clks.
- Fade, with RISC8_PWM_FADE_EN: from active=0, write shadow=3 (WIDTH=4).
  - On-ticks must be 1, 2, 3, 3 across the next four periods.
  - Then write 0: on-ticks must be 2, 1, 0.
